shift_pipe: RTL and testbench

SHIFT_PIPE -- requirements
Module: shift_pipe

---
 rtl/shift_pipe_if.sv | 27 ++
 rtl/shift_pipe.sv | 125 ++++++++++++
 tb/tb_shift_pipe.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_pipe_if.sv
// Operand/result handshake bundle for the pipelined barrel shifter.
// The producer side uses master; the shifter itself uses slave.
interface shift_pipe_if #(
    parameter int WIDTH = 64,
    parameter int SHW   = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_shamt;
    logic [2:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;
    logic             out_err;

    modport master (
        output in_valid, in_data, in_shamt, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_zero, out_err
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_op, out_ready,
        output in_ready, out_valid, out_data, out_zero, out_err
    );
endinterface

// File: rtl/shift_pipe.sv
// Pipelined logarithmic shifter: SHW conditional power-of-two stages, with a
// register bank after every REG_EVERY stages and a global stall from the output.
module shift_pipe #(
    parameter int WIDTH     = 64,
    parameter int SHW       = $clog2(WIDTH),
    parameter int REG_EVERY = 2
) (
    input logic         clk,
    input logic         rst,
    shift_pipe_if.slave bus
);
    localparam int NREG = (SHW + REG_EVERY - 1) / REG_EVERY;

    logic stall;

    assign stall        = bus.out_valid && !bus.out_ready;
    assign bus.in_ready = !stall;

    // Applies log-shifter stages lo..hi-1; the original sign bit is carried so
    // SRA fill stays correct even after earlier stages moved the MSB.
    function automatic logic [WIDTH-1:0] shift_stages(
        input logic [WIDTH-1:0] x,
        input logic [SHW-1:0]   shamt,
        input logic [2:0]       op,
        input logic             sign,
        input int               lo,
        input int               hi
    );
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] fill;
        r = x;
        for (int k = 0; k < SHW; k++) begin
            fill = ~({WIDTH{1'b1}} >> (2**k));
            if (k >= lo && k < hi && shamt[k]) begin
                case (op)
                    3'b000:  r = r << (2**k);
                    3'b001:  r = r >> (2**k);
                    3'b010:  r = (r >> (2**k)) | (sign ? fill : '0);
                    3'b011:  r = (r << (2**k)) | (r >> (WIDTH - 2**k));
                    3'b100:  r = (r >> (2**k)) | (r << (WIDTH - 2**k));
                    default: r = r;
                endcase
            end
        end
        return r;
    endfunction

    for (genvar b = 0; b < NREG; b++) begin : bank
        localparam int LO = b * REG_EVERY;
        localparam int HI = ((b + 1) * REG_EVERY > SHW) ? SHW : (b + 1) * REG_EVERY;

        logic             v_i;
        logic [WIDTH-1:0] d_i;
        logic [SHW-1:0]   sh_i;
        logic [2:0]       op_i;
        logic             sg_i;
        logic [WIDTH-1:0] d_next;
        logic             v_q;
        logic [WIDTH-1:0] d_q;

        if (b == 0) begin : src
            assign v_i  = bus.in_valid;
            assign d_i  = bus.in_data;
            assign sh_i = bus.in_shamt;
            assign op_i = bus.in_op;
            assign sg_i = bus.in_data[WIDTH-1];
        end else begin : src
            assign v_i  = bank[b-1].v_q;
            assign d_i  = bank[b-1].d_q;
            assign sh_i = bank[b-1].mid.sh_q;
            assign op_i = bank[b-1].mid.op_q;
            assign sg_i = bank[b-1].mid.sg_q;
        end

        assign d_next = shift_stages(d_i, sh_i, op_i, sg_i, LO, HI);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q <= 1'b0;
                d_q <= '0;
            end else if (!stall) begin
                v_q <= v_i;
                d_q <= d_next;
            end
        end

        // Intermediate banks still need the control fields; the last bank only
        // keeps the flags the consumer sees, since no shift bits remain.
        if (b < NREG - 1) begin : mid
            logic [SHW-1:0] sh_q;
            logic [2:0]     op_q;
            logic           sg_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sh_q <= '0;
                    op_q <= '0;
                    sg_q <= 1'b0;
                end else if (!stall) begin
                    sh_q <= sh_i;
                    op_q <= op_i;
                    sg_q <= sg_i;
                end
            end
        end else begin : fin
            logic zero_q;
            logic err_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    zero_q <= 1'b0;
                    err_q  <= 1'b0;
                end else if (!stall) begin
                    zero_q <= (d_next == '0);
                    err_q  <= (op_i > 3'd4);
                end
            end
        end
    end

    assign bus.out_valid = bank[NREG-1].v_q;
    assign bus.out_data  = bank[NREG-1].d_q;
    assign bus.out_zero  = bank[NREG-1].fin.zero_q;
    assign bus.out_err   = bank[NREG-1].fin.err_q;
endmodule

// File: tb/tb_shift_pipe.sv
// Scoreboard bench for shift_pipe: a driver pushes expected results on each
// accepted operand and an independent monitor pops and compares on each output.
module tb_shift_pipe;
    localparam int WIDTH     = 64;
    localparam int SHW       = 6;
    localparam int REG_EVERY = 2;
    localparam int LAT       = 3;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             zero;
        logic             err;
        int               cyc;
        int               stl;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    shift_pipe_if #(.WIDTH(WIDTH)) bus();

    shift_pipe #(.WIDTH(WIDTH), .REG_EVERY(REG_EVERY)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    exp_t             sbq[$];
    int               n_cmp = 0;
    int               n_bad = 0;
    int               cyc = 0;
    int               stl = 0;
    bit               force_low = 1'b0;
    bit               rand_ready = 1'b0;
    bit               prev_stall = 1'b0;
    logic [WIDTH-1:0] h_data;
    logic             h_zero;
    logic             h_err;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, req);
        end
    endtask

    // Reference result computed from the whole shift amount at once.
    function automatic exp_t model(input logic [WIDTH-1:0] data, input logic [SHW-1:0] shamt,
                                   input logic [2:0] op);
        exp_t e;
        int   n;
        n     = int'(shamt) % WIDTH;
        e.err = 1'b0;
        case (op)
            3'd0:    e.data = data << n;
            3'd1:    e.data = data >> n;
            3'd2:    e.data = $signed(data) >>> n;
            3'd3:    e.data = (data << n) | (data >> (WIDTH - n));
            3'd4:    e.data = (data >> n) | (data << (WIDTH - n));
            default: begin
                e.data = data;
                e.err  = 1'b1;
            end
        endcase
        e.zero = (e.data == '0);
        e.cyc  = 0;
        e.stl  = 0;
        return e;
    endfunction

    task automatic applyStimulus(input logic [WIDTH-1:0] data, input logic [SHW-1:0] shamt,
                                 input logic [2:0] op, input bit directed = 1'b0,
                                 input logic [WIDTH-1:0] exp_data = '0, input bit exp_err = 1'b0);
        exp_t e;
        int   guard;
        e = model(data, shamt, op);
        if (directed) begin
            e.data = exp_data;
            e.err  = exp_err;
            e.zero = (exp_data == '0);
        end
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.in_shamt = shamt;
        bus.in_op    = op;
        #1;
        guard = 0;
        while (!bus.in_ready) begin
            guard++;
            if (guard > 100) begin
                n_cmp++;
                n_bad++;
                $display("[TB] FAIL accept_timeout: got in_ready=0 for %0d cycles, expected acceptance", guard);
                bus.in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
        end
        e.cyc = cyc;
        e.stl = stl;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic checkReset(input string tag);
        chk({tag, "_out_valid"}, WIDTH'(bus.out_valid), '0);
        chk({tag, "_out_data"},  bus.out_data, '0);
        chk({tag, "_out_zero"},  WIDTH'(bus.out_zero), '0);
        chk({tag, "_out_err"},   WIDTH'(bus.out_err), '0);
        chk({tag, "_in_ready"},  WIDTH'(bus.in_ready), WIDTH'(1));
    endtask

    task automatic checkOutput();
        exp_t e;
        if (rst) begin
            prev_stall = 1'b0;
            return;
        end
        if (prev_stall) begin
            chk("hold_valid", WIDTH'(bus.out_valid), WIDTH'(1));
            chk("hold_data",  bus.out_data, h_data);
            chk("hold_zero",  WIDTH'(bus.out_zero), WIDTH'(h_zero));
            chk("hold_err",   WIDTH'(bus.out_err), WIDTH'(h_err));
        end
        if (bus.out_valid && bus.out_ready) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("[TB] FAIL unexpected_output: got data 0x%h, expected no result", bus.out_data);
            end else begin
                e = sbq.pop_front();
                chk("out_data", bus.out_data, e.data);
                chk("out_zero", WIDTH'(bus.out_zero), WIDTH'(e.zero));
                chk("out_err",  WIDTH'(bus.out_err), WIDTH'(e.err));
                chk("latency",  WIDTH'(cyc - e.cyc), WIDTH'(LAT + (stl - e.stl)));
            end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        h_data     = bus.out_data;
        h_zero     = bus.out_zero;
        h_err      = bus.out_err;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // A stall cycle delays every in-flight result by exactly one cycle.
    initial forever begin
        @(negedge clk);
        #3;
        if (!rst && bus.out_valid && !bus.out_ready) stl++;
    end

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(negedge clk);
            bus.out_ready = force_low ? 1'b0 : (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
    end

    initial forever begin
        @(negedge clk);
        #2;
        checkOutput();
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int guard;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_shamt = '0;
        bus.in_op    = '0;
        #1;
        checkReset("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(2);

        applyStimulus(64'h8000_0000_0000_0001, 6'd4,  3'b010, 1'b1, 64'hF800_0000_0000_0000, 1'b0);
        applyStimulus(64'h0000_0000_0000_00FF, 6'd8,  3'b100, 1'b1, 64'hFF00_0000_0000_0000, 1'b0);
        applyStimulus(64'hFF00_0000_0000_0000, 6'd8,  3'b011, 1'b1, 64'h0000_0000_0000_00FF, 1'b0);
        applyStimulus(64'h1,                   6'd63, 3'b000, 1'b1, 64'h8000_0000_0000_0000, 1'b0);
        applyStimulus(64'h8000_0000_0000_0000, 6'd63, 3'b001, 1'b1, 64'h1,                   1'b0);
        applyStimulus(64'h1,                   6'd0,  3'b000, 1'b1, 64'h1,                   1'b0);
        applyStimulus(64'h1234,                6'd5,  3'b111, 1'b1, 64'h1234,                1'b1);
        applyStimulus(64'h1,                   6'd1,  3'b001, 1'b1, 64'h0,                   1'b0);
        applyStimulus(64'hDEAD_BEEF_0000_0001, 6'd0,  3'b010, 1'b1, 64'hDEAD_BEEF_0000_0001, 1'b0);
        idle(6);

        // Eight back-to-back operands with the consumer blocked for four cycles.
        @(posedge clk);
        #1;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    applyStimulus(64'h0123_4567_89AB_CDEF, 6'(i * 7), 3'(i % 5));
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                force_low = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    #1;
                    chk("stall_in_ready", WIDTH'(bus.in_ready), '0);
                end
                @(posedge clk);
                #1;
                force_low = 1'b0;
            end
        join
        idle(6);

        // Reset with three operands in flight; none of them may emerge later.
        applyStimulus(64'hAAAA_0000_0000_0001, 6'd3, 3'b000);
        applyStimulus(64'hAAAA_0000_0000_0002, 6'd3, 3'b001);
        applyStimulus(64'hAAAA_0000_0000_0003, 6'd3, 3'b011);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkReset("midreset");
        sbq.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(6);
        applyStimulus(64'h0F0F_0000_0000_0000, 6'd12, 3'b100);
        idle(6);

        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [WIDTH-1:0] d;
            logic [2:0]       op;
            d  = {$urandom, $urandom};
            op = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            applyStimulus(d, 6'($urandom_range(0, 63)), op);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        rand_ready = 1'b0;

        guard = 0;
        while (sbq.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        #3;
        chk("drain_empty", WIDTH'(sbq.size()), '0);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
